// File: rtl/divider_pkg.sv
// Shared widths, FSM encoding and constants for the divider sequencer.
package divider_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } seq_state_t;

endpackage

// File: rtl/div_timeout_counter.sv
// WAIT-cycle counter; expired is combinational and high during the LIMIT-th enabled cycle.
// No backpressure: clear has priority over enable.
module div_timeout_counter #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // count starts at 0 on the first WAIT cycle, so this marks the last allowed WAIT cycle.
  assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/divider_sequencer.sv
// Sequences one request through an external divider; response one cycle after done (DBZ: after accept).
// One operation in flight; req_ready only in IDLE, response held until rsp_ready.
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  output logic              div_load,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_quotient,
  output logic [DATA_W-1:0] rsp_remainder,
  output logic              rsp_dbz,
  output logic              rsp_timeout,
  output logic              busy
);

  seq_state_t        state;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic              in_wait;
  logic              expired;

  assign in_wait      = (state == WAIT);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

  div_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      div_load      <= 1'b0;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dividend_q <= req_dividend;
            divisor_q  <= req_divisor;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (req_divisor != '0) begin
              state    <= LOAD;
              div_load <= 1'b1;
            end else begin
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_quotient  <= DBZ_QUOTIENT;
              rsp_remainder <= req_dividend;
              rsp_dbz       <= 1'b1;
              rsp_timeout   <= 1'b0;
            end
          end
        end
        // div_done may still be high from the previous operation here, so it is not looked at.
        LOAD: begin
          state    <= WAIT;
          div_load <= 1'b0;
        end
        WAIT: begin
          if (div_done) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b0;
          end else if (expired) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          div_load  <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/divider_sequencer.md
DIVIDER_SEQUENCER -- requirements
Module: divider_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 32, maximum WAIT cycles before abort (legal range 16..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  in  1  request offered.
REQ-005 SHALL have port: req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port: req_dividend  in  8  unsigned dividend.
REQ-007 SHALL have port: req_divisor  in  8  unsigned divisor.
REQ-008 SHALL have port: div_load  out  1  one-cycle load pulse to the restoring divider.
REQ-009 SHALL have port: div_dividend / div_divisor  out  8 each  operands to the divider.
REQ-010 SHALL have port: div_done  in  1  divider completion level.
REQ-011 SHALL have port: div_quotient / div_remainder  in  8 each  divider results.
REQ-012 SHALL have port: rsp_valid  out  1  response available.
REQ-013 SHALL have port: rsp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port: rsp_quotient / rsp_remainder  out  8 each  result.
REQ-015 SHALL have port: rsp_dbz  out  1  divide-by-zero flag; rsp_timeout  out  1  abort flag.
REQ-016 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT, RESP.
REQ-018 req_ready SHALL be high only in IDLE; req_valid && req_ready is acceptance; operands SHALL be captured into internal registers on that edge.
REQ-019 IDLE, accepted with req_divisor != 0 -> LOAD; with req_divisor == 0 -> RESP directly, div_load never pulsed.
REQ-020 LOAD SHALL last exactly one cycle with div_load = 1, then -> WAIT; div_load SHALL be 0 in every other state.
REQ-021 div_done SHALL be ignored in LOAD (stale done from previous op); it SHALL be sampled only in WAIT.
REQ-022 div_dividend/div_divisor SHALL be driven from captured registers, stable from LOAD through RESP.
REQ-023 WAIT: on div_done = 1 capture div_quotient/div_remainder, rsp_dbz = 0, rsp_timeout = 0, -> RESP.
REQ-024 WAIT cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES with div_done still 0 -> RESP with quotient 8'h00, remainder 8'h00, rsp_timeout = 1; done and timeout in the same cycle: done wins.
REQ-025 Divide-by-zero response: quotient 8'hFF, remainder = captured dividend, rsp_dbz = 1, rsp_timeout = 0.
REQ-026 rsp_valid SHALL be high only in RESP; all rsp_* outputs SHALL hold stable while rsp_valid && !rsp_ready.
REQ-027 RESP with rsp_ready = 1 -> IDLE; req_ready SHALL not rise until the following cycle (no same-cycle turnaround).
REQ-028 Normal-path latency: rsp_valid SHALL rise the cycle after div_done is sampled high in WAIT; DBZ path: rsp_valid SHALL rise the cycle after acceptance.
REQ-029 req_valid changes outside IDLE SHALL have no effect.

Reset
REQ-030 reset low SHALL immediately force IDLE, req_ready = 1 after release, div_load = 0, rsp_valid = 0, rsp_* data/flags = 0, busy = 0, counter = 0, operand registers = 0.
REQ-031 reset asserted mid-operation (LOAD/WAIT/RESP) SHALL discard the operation; no response SHALL be emitted afterwards.

Structure
REQ-032 Shared package divider_pkg SHALL hold DATA_W = 8, state enum encoding, DBZ_QUOTIENT = 8'hFF.
REQ-033 WAIT timeout counter SHALL be a sub-module div_timeout_counter (clear, enable, expired output).

Verification
REQ-034 Accept 100/7 -> one div_load pulse, after div_done: rsp_quotient 14, rsp_remainder 2, flags 0.
REQ-035 Accept 55/0 -> no div_load, rsp_valid next cycle, quotient 8'hFF, remainder 55, rsp_dbz 1.
REQ-036 Accept 9/3 with div_done tied 0 -> rsp_valid after 32 WAIT cycles, quotient 0, remainder 0, rsp_timeout 1.
REQ-037 rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready 0; new req_valid ignored until one cycle after handshake.
REQ-038 Stale div_done = 1 during LOAD -> ignored; response only after fresh done in WAIT.
REQ-039 reset low during WAIT -> busy 0, rsp_valid 0; late div_done after release produces no response.
